// File: rtl/floatingpoint_divider.sv
// ---------------------------------------------------------------------------
// floatingpoint_divider
//
// Sequential IEEE-754 binary32 divider (dataA_i / dataB_i). A restoring
// mantissa divider produces one quotient bit per clock. The result is
// truncated (no rounding), matching the companion combinational multiplier.
// Fixed latency: 26 cycles from the start edge to the done_o edge.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset
//   start_i    operation request, sampled only while idle
//   dataA_i    dividend, captured with start_i
//   dataB_i    divisor, captured with start_i
//   busy_o     operation in progress
//   done_o     one-cycle pulse, data_o/divzero_o valid
//   data_o     quotient, held until the next done_o
//   divzero_o  divide-by-zero flag, updated with done_o
// ---------------------------------------------------------------------------
module floatingpoint_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dataA_i,
    input  logic [DATA_WIDTH-1:0] dataB_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  divzero_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2
    } state_t;

    // Special-case classes decided when operands are captured
    localparam logic [1:0] SP_NONE  = 2'd0;
    localparam logic [1:0] SP_NAN   = 2'd1;
    localparam logic [1:0] SP_DIVZ  = 2'd2;
    localparam logic [1:0] SP_AZERO = 2'd3;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    divzero_q, divzero_d;
    logic [25:0]             r_q, r_d;
    logic [24:0]             quo_q, quo_d;
    logic [23:0]             mb_q, mb_d;
    logic signed [9:0]       exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic [1:0]              special_q, special_d;
    logic [4:0]              cnt_q, cnt_d;

    // Operand field views
    logic [7:0]              exp_a_s, exp_b_s;
    logic [1:0]              special_s;
    logic signed [9:0]       exp_in_s;

    // Restoring-step and packing intermediates
    logic                    qbit_s;
    logic [25:0]             rem_s;
    logic signed [9:0]       exp_fin_s;
    logic [22:0]             mant_s;
    logic [DATA_WIDTH-1:0]   pack_s;

    assign exp_a_s  = dataA_i[30:23];
    assign exp_b_s  = dataB_i[30:23];
    // Biased exponent difference; 10-bit signed holds -128..382 without wrap
    assign exp_in_s = $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s}) + 10'sd127;

    // Classify operands by priority: NaN/Inf input, zero divisor, zero dividend
    always_comb begin
        if ((exp_a_s == 8'hFF) || (exp_b_s == 8'hFF)) begin
            special_s = SP_NAN;
        end else if (exp_b_s == 8'h00) begin
            special_s = SP_DIVZ;
        end else if (exp_a_s == 8'h00) begin
            special_s = SP_AZERO;
        end else begin
            special_s = SP_NONE;
        end
    end

    // One restoring step: subtract divisor when it fits, then shift
    always_comb begin
        if (r_q >= {2'b00, mb_q}) begin
            qbit_s = 1'b1;
            rem_s  = r_q - {2'b00, mb_q};
        end else begin
            qbit_s = 1'b0;
            rem_s  = r_q;
        end
    end

    // Normalise the quotient and apply special/overflow/underflow overrides
    always_comb begin
        if (quo_q[24]) begin
            mant_s    = quo_q[23:1];
            exp_fin_s = exp_q;
        end else begin
            mant_s    = quo_q[22:0];
            exp_fin_s = exp_q - 10'sd1;
        end
        case (special_q)
            SP_NAN:   pack_s = 32'h7FC0_0000;
            SP_DIVZ:  pack_s = {sign_q, 8'hFF, 23'h000000};
            SP_AZERO: pack_s = {sign_q, 31'h0000_0000};
            default: begin
                if (exp_fin_s >= 10'sd255) begin
                    pack_s = {sign_q, 8'hFF, 23'h000000};
                end else if (exp_fin_s <= 10'sd0) begin
                    pack_s = {sign_q, 31'h0000_0000};
                end else begin
                    pack_s = {sign_q, exp_fin_s[7:0], mant_s};
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DIVIDE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_DIVIDE;
                end
            end
            S_NORM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_d    = data_q;
        divzero_d = divzero_q;
        r_d       = r_q;
        quo_d     = quo_q;
        mb_d      = mb_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        special_d = special_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    busy_d    = 1'b1;
                    sign_d    = dataA_i[31] ^ dataB_i[31];
                    r_d       = {2'b00, 1'b1, dataA_i[22:0]};
                    mb_d      = {1'b1, dataB_i[22:0]};
                    exp_d     = exp_in_s;
                    special_d = special_s;
                    quo_d     = 25'd0;
                    cnt_d     = 5'd0;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            S_DIVIDE: begin
                // Quotient bits enter at the LSB so the first lands in quo[24]
                quo_d = {quo_q[23:0], qbit_s};
                r_d   = rem_s << 1;
                cnt_d = cnt_q + 5'd1;
            end
            S_NORM: begin
                data_d    = pack_s;
                divzero_d = (special_q == SP_DIVZ);
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            divzero_q <= 1'b0;
            r_q       <= 26'd0;
            quo_q     <= 25'd0;
            mb_q      <= 24'd0;
            exp_q     <= 10'sd0;
            sign_q    <= 1'b0;
            special_q <= SP_NONE;
            cnt_q     <= 5'd0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
            divzero_q <= divzero_d;
            r_q       <= r_d;
            quo_q     <= quo_d;
            mb_q      <= mb_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            special_q <= special_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign data_o    = data_q;
    assign divzero_o = divzero_q;

endmodule
